// File: rtl/tcdm_bank_xbar.sv
// Word-interleaved TCDM crossbar: NB_IN initiators onto NB_BANKS banks,
// runtime arbitration policy, starvation guard, fixed-latency responses.
module tcdm_bank_xbar #(
   parameter int NB_IN = 16,
   parameter int NB_BANKS = 16,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 32,
   parameter int ADDR_MEM_WIDTH = 11,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h1000_0000,
   parameter int RESP_LAT = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [1:0]                               arb_policy_i,
   input  logic [NB_IN-1:0]                         req_i,
   input  logic [NB_IN-1:0][ADDR_WIDTH-1:0]         add_i,
   input  logic [NB_IN-1:0]                         wen_i,
   input  logic [NB_IN-1:0][DATA_WIDTH-1:0]         wdata_i,
   input  logic [NB_IN-1:0][BE_WIDTH-1:0]           be_i,
   output logic [NB_IN-1:0]                         gnt_o,
   output logic [NB_IN-1:0]                         r_valid_o,
   output logic [NB_IN-1:0][DATA_WIDTH-1:0]         r_rdata_o,
   output logic [NB_BANKS-1:0]                      req_o,
   output logic [NB_BANKS-1:0][ADDR_MEM_WIDTH-1:0]  add_o,
   output logic [NB_BANKS-1:0]                      wen_o,
   output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]      wdata_o,
   output logic [NB_BANKS-1:0][BE_WIDTH-1:0]        be_o,
   input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]      rdata_i
);

   localparam int BOFF = $clog2(BE_WIDTH);
   localparam int BB = $clog2(NB_BANKS);
   localparam int IW = $clog2(NB_IN);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [NB_IN-1:0][ADDR_WIDTH-1:0] off;
   logic [NB_IN-1:0][BB-1:0] bank_sel;
   logic [NB_IN-1:0][ADDR_MEM_WIDTH-1:0] row;
   logic [NB_BANKS-1:0][NB_IN-1:0] breq;
   logic [NB_BANKS-1:0][IW-1:0] win;
   logic [NB_BANKS-1:0] win_vld;
   logic [NB_BANKS-1:0][IW-1:0] rr_ptr;
   logic [NB_IN-1:0][CW-1:0] wait_cnt;
   logic [NB_IN-1:0] starved;
   logic [NB_IN-1:0][RESP_LAT-1:0] vld_q;
   logic [NB_IN-1:0][BB-1:0] bank_q;
   logic [NB_IN-1:0][DATA_WIDTH-1:0] s1_data;
   logic [NB_IN-1:0][DATA_WIDTH-1:0] rsp_data;
   logic unused_off;

   // Offset bits outside bank/row are intentionally dropped (wrapping).
   assign unused_off = ^off;

   always_comb begin
      off = '0;
      bank_sel = '0;
      row = '0;
      starved = '0;
      for (int p = 0; p < NB_IN; p++) begin
         off[p] = add_i[p] - BASE_ADDR;
         bank_sel[p] = off[p][BOFF +: BB];
         row[p] = off[p][BOFF + BB +: ADDR_MEM_WIDTH];
         starved[p] = (wait_cnt[p] == LIM);
      end
   end

   always_comb begin
      breq = '0;
      for (int b = 0; b < NB_BANKS; b++)
         for (int p = 0; p < NB_IN; p++)
            breq[b][p] = req_i[p] && !rst_i && (bank_sel[p] == BB'(b));
   end

   always_comb begin
      win = '0;
      win_vld = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         win_vld[b] = |breq[b];
         unique case (arb_policy_i)
            2'b00: begin
               // Descending scan so the nearest requester after rr_ptr wins.
               for (int k = NB_IN - 1; k >= 0; k--) begin
                  int j;
                  j = int'(rr_ptr[b]) + k;
                  if (j >= NB_IN) j = j - NB_IN;
                  if (breq[b][j]) win[b] = IW'(j);
               end
            end
            2'b01: begin
               for (int p = NB_IN - 1; p >= 0; p--)
                  if (breq[b][p]) win[b] = IW'(p);
            end
            2'b10: begin
               for (int p = 0; p < NB_IN; p++)
                  if (breq[b][p]) win[b] = IW'(p);
            end
            default: begin
               for (int p = NB_IN - 1; p >= 0; p--)
                  if (breq[b][p]) win[b] = IW'(p);
               for (int p = NB_IN - 1; p >= 0; p--)
                  if (breq[b][p] && starved[p]) win[b] = IW'(p);
            end
         endcase
      end
   end

   always_comb begin
      gnt_o = '0;
      for (int p = 0; p < NB_IN; p++)
         gnt_o[p] = req_i[p] && !rst_i && win_vld[bank_sel[p]]
                    && (win[bank_sel[p]] == IW'(p));
   end

   always_comb begin
      req_o = '0;
      add_o = '0;
      wen_o = '0;
      wdata_o = '0;
      be_o = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         if (win_vld[b]) begin
            req_o[b] = 1'b1;
            add_o[b] = row[win[b]];
            wen_o[b] = wen_i[win[b]];
            wdata_o[b] = wdata_i[win[b]];
            be_o[b] = be_i[win[b]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
         wait_cnt <= '0;
      end else begin
         for (int b = 0; b < NB_BANKS; b++) begin
            if (arb_policy_i == 2'b00 && win_vld[b]) begin
               if (int'(win[b]) == NB_IN - 1) rr_ptr[b] <= '0;
               else rr_ptr[b] <= win[b] + IW'(1);
            end
         end
         for (int p = 0; p < NB_IN; p++) begin
            if (req_i[p] && !gnt_o[p]) begin
               if (wait_cnt[p] != LIM) wait_cnt[p] <= wait_cnt[p] + CW'(1);
            end else begin
               wait_cnt[p] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         bank_q <= '0;
      end else begin
         for (int p = 0; p < NB_IN; p++) begin
            vld_q[p][0] <= gnt_o[p];
            for (int s = 1; s < RESP_LAT; s++)
               vld_q[p][s] <= vld_q[p][s-1];
            bank_q[p] <= bank_sel[p];
         end
      end
   end

   always_comb begin
      s1_data = '0;
      for (int p = 0; p < NB_IN; p++)
         s1_data[p] = rdata_i[bank_q[p]];
   end

   generate
      if (RESP_LAT == 1) begin : g_lat1
         assign rsp_data = s1_data;
      end else begin : g_latn
         logic [NB_IN-1:0][RESP_LAT-2:0][DATA_WIDTH-1:0] dat_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               dat_q <= '0;
            end else begin
               for (int p = 0; p < NB_IN; p++) begin
                  dat_q[p][0] <= s1_data[p];
                  for (int s = 1; s < RESP_LAT - 1; s++)
                     dat_q[p][s] <= dat_q[p][s-1];
               end
            end
         end

         always_comb begin
            rsp_data = '0;
            for (int p = 0; p < NB_IN; p++)
               rsp_data[p] = dat_q[p][RESP_LAT-2];
         end
      end
   endgenerate

   always_comb begin
      r_valid_o = '0;
      r_rdata_o = '0;
      for (int p = 0; p < NB_IN; p++) begin
         r_valid_o[p] = !rst_i && vld_q[p][RESP_LAT-1];
         r_rdata_o[p] = rst_i ? '0 : rsp_data[p];
      end
   end

endmodule

// File: tb/tb_tcdm_bank_xbar.sv
// Directed bench for tcdm_bank_xbar: grant checks inline, responses
// checked against a queue of expected {port, data, due cycle}.
module tb_tcdm_bank_xbar;

   localparam int NI = 16;
   localparam int NBK = 16;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int AMW = 11;
   localparam int BEW = 4;
   localparam int LAT = 2;
   localparam int SL = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] pol;
   logic [NI-1:0] req, wen, gnt, rvld;
   logic [NI-1:0][AW-1:0] add;
   logic [NI-1:0][DW-1:0] wdata, rdata_o;
   logic [NI-1:0][BEW-1:0] be;
   logic [NBK-1:0] breq, bwen;
   logic [NBK-1:0][AMW-1:0] badd;
   logic [NBK-1:0][DW-1:0] bwdata, brdata;
   logic [NBK-1:0][BEW-1:0] bbe;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int port;
      logic [31:0] data;
      bit chk_data;
      int due;
   } rsp_t;
   rsp_t q[$];

   tcdm_bank_xbar #(
      .NB_IN(NI), .NB_BANKS(NBK), .DATA_WIDTH(DW), .BE_WIDTH(BEW),
      .ADDR_WIDTH(AW), .ADDR_MEM_WIDTH(AMW), .BASE_ADDR(BASE),
      .RESP_LAT(LAT), .STARVE_LIMIT(SL)
   ) dut (
      .clk_i(clk), .rst_i(rst), .arb_policy_i(pol),
      .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt), .r_valid_o(rvld), .r_rdata_o(rdata_o),
      .req_o(breq), .add_o(badd), .wen_o(bwen), .wdata_o(bwdata),
      .be_o(bbe), .rdata_i(brdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rd(int b, int c);
      return (32'(c) << 8) | 32'(b);
   endfunction

   always_comb begin
      brdata = '0;
      for (int b = 0; b < NBK; b++) brdata[b] = rd(b, cyc);
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      req = '0;
      wen = '1;
      add = '0;
      wdata = '0;
      be = '0;
   endtask

   task automatic drv(int p, int b, bit w, logic [31:0] d);
      req[p] = 1'b1;
      add[p] = BASE + 32'(b * 4);
      wen[p] = w;
      wdata[p] = d;
      be[p] = 4'hF;
   endtask

   task automatic exp_grant(string tag, int p, int b, bit dchk);
      chk(tag, 64'(gnt), 64'(1) << p);
      chk({tag, "_breq"}, 64'(breq[b]), 64'(1));
      q.push_back('{port: p, data: rd(b, cyc + 1), chk_data: dchk,
                    due: cyc + LAT});
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         nxt();
      end
   endtask

   always @(negedge clk) begin
      rsp_t e;
      if (!rst && (rvld != '0 || (q.size() > 0 && q[0].due <= cyc))) begin
         if (q.size() == 0) begin
            chk("rsp_unexpected", 64'(rvld), 64'(0));
         end else begin
            e = q.pop_front();
            chk("rsp_valid", 64'(rvld), 64'(1) << e.port);
            chk("rsp_cycle", 64'(cyc), 64'(e.due));
            if (e.chk_data) chk("rsp_data", 64'(rdata_o[e.port]), 64'(e.data));
         end
      end
   end

   initial begin
      int exp_p;
      rst = 1'b1;
      pol = 2'b00;
      clr();
      for (int p = 0; p < NI; p++) drv(p, 0, 1'b1, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_gnt", 64'(gnt), 64'(0));
         chk("rst_rvld", 64'(rvld), 64'(0));
         chk("rst_breq", 64'(breq), 64'(0));
         chk("rst_rdata", 64'(rdata_o[0]), 64'(0));
         chk("rst_badd", 64'(badd[0]), 64'(0));
         nxt();
      end
      rst = 1'b0;
      @(negedge clk);
      exp_grant("first_gnt", 0, 0, 1'b1);
      nxt();
      clr();
      idle(2);

      // interleaving: 0x1000_0044 -> bank 1, row 1
      drv(3, 0, 1'b1, '0);
      add[3] = 32'h1000_0044;
      @(negedge clk);
      exp_grant("ilv_gnt", 3, 1, 1'b1);
      chk("ilv_row", 64'(badd[1]), 64'(1));
      chk("ilv_wen", 64'(bwen[1]), 64'(1));
      nxt();
      clr();
      idle(3);

      drv(0, 2, 1'b1, '0);
      drv(5, 2, 1'b1, '0);
      drv(9, 2, 1'b1, '0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp_p = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 5 : 9;
         exp_grant("rr_gnt", exp_p, 2, 1'b1);
         nxt();
      end
      clr();
      idle(3);

      pol = 2'b10;
      drv(1, 7, 1'b1, '0);
      drv(14, 7, 1'b1, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_grant("hi_gnt", 14, 7, 1'b1);
         nxt();
      end
      pol = 2'b01;
      @(negedge clk);
      exp_grant("lo_gnt", 1, 7, 1'b1);
      nxt();
      clr();
      idle(3);

      pol = 2'b11;
      drv(0, 3, 1'b1, '0);
      drv(6, 3, 1'b1, '0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         exp_grant("starve_gnt", (i % 5 == 0) ? 6 : 0, 3, 1'b1);
         nxt();
      end
      clr();
      idle(3);

      pol = 2'b00;
      for (int b = 0; b < 4; b++) begin
         clr();
         drv(2, b, 1'b0, 32'hA500_0000 | 32'(b));
         @(negedge clk);
         exp_grant("wr_gnt", 2, b, 1'b0);
         chk("wr_wen", 64'(bwen[b]), 64'(0));
         chk("wr_wdata", 64'(bwdata[b]), 64'(32'hA500_0000 | 32'(b)));
         chk("wr_be", 64'(bbe[b]), 64'(4'hF));
         nxt();
      end
      clr();
      idle(3);

      for (int b = 0; b < 2; b++) begin
         clr();
         drv(2, b, 1'b0, 32'h5A00_0000 | 32'(b));
         @(negedge clk);
         exp_grant("mid_gnt", 2, b, 1'b0);
         nxt();
      end
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("mid_rst_gnt", 64'(gnt), 64'(0));
      chk("mid_rst_rvld", 64'(rvld), 64'(0));
      chk("mid_rst_wdata", 64'(bwdata[2]), 64'(0));
      nxt();
      rst = 1'b0;
      clr();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_rvld", 64'(rvld), 64'(0));
         nxt();
      end

      // bank 1 pointer was 3 before reset; a cleared pointer picks port 2
      drv(2, 1, 1'b1, '0);
      drv(5, 1, 1'b1, '0);
      @(negedge clk);
      exp_grant("rr_restart", 2, 1, 1'b1);
      nxt();
      clr();

      for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
      chk("drain", 64'(q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_xbar.md
# tcdm_bank_xbar

Parametrised, registered-response TCDM crossbar connecting NB_IN initiator ports (cores, HWPE ports, external/DMA ports) to NB_BANKS word-interleaved SRAM banks inside the cluster. It is the successor to the fixed-latency LIC wrapper. It adds runtime-selectable arbitration policies, a starvation guard, base-address rebasing and a configurable response pipeline depth. It sits between the initiator bind logic and the TCDM bank macros.

## Interface
- NB_IN, 16, number of initiator ports
- NB_BANKS, 16, number of banks; power of two, ≥2
- DATA_WIDTH, 32, word width; BE_WIDTH = DATA_WIDTH/8
- ADDR_WIDTH, 32, initiator address width
- ADDR_MEM_WIDTH, 11, bank row address width
- BASE_ADDR, 32'h1000_0000, subtracted from every initiator address
- RESP_LAT, 1, cycles from grant to r_valid_o; legal 1..3
- STARVE_LIMIT, 8, consecutive lost cycles before a port is promoted; ≥1
- clk_i in 1: clock
- rst_i in 1: synchronous, active-high reset
- arb_policy_i in 2: 00 round-robin, 01 fixed low-index-first, 10 fixed high-index-first, 11 low-index-first with starvation guard
- req_i in NB_IN: request per port
- add_i in NB_IN×ADDR_WIDTH: byte address
- wen_i in NB_IN: 1 = read, 0 = write
- wdata_i in NB_IN×DATA_WIDTH: write data
- be_i in NB_IN×BE_WIDTH: byte enables
- gnt_o out NB_IN: grant, combinational in the request cycle
- r_valid_o out NB_IN: response valid, for both reads and writes
- r_rdata_o out NB_IN×DATA_WIDTH: read data, valid with r_valid_o
- req_o out NB_BANKS: bank request
- add_o out NB_BANKS×ADDR_MEM_WIDTH: bank row
- wen_o, wdata_o, be_o out per bank: forwarded from the winning port
- rdata_i in NB_BANKS×DATA_WIDTH: bank data, valid one cycle after req_o

## Operation
- Address decode:
  - off = add_i − BASE_ADDR, modulo 2^ADDR_WIDTH.
  - Bits [log2(BE_WIDTH)-1:0] are the byte offset and are dropped.
  - The next log2(NB_BANKS) bits select the bank.
  - The next ADDR_MEM_WIDTH bits form the row.
  - Upper bits are ignored, so out-of-range addresses wrap.
- Banks are always ready. Each bank grants at most one port per cycle. A port targets exactly one bank, so each port receives at most one grant.
- Per-bank arbitration among requesting ports:
  - 00: winner is the first requester at or after rr_ptr[bank], searching cyclically. On a grant, rr_ptr[bank] ← winner+1 mod NB_IN.
  - 01: lowest requesting index wins.
  - 10: highest requesting index wins.
  - 11: the lowest-index requester with wait_cnt == STARVE_LIMIT wins. If none is starved, the lowest requesting index wins.
- wait_cnt[port]:
  - Increments, saturating at STARVE_LIMIT, when req_i is high and gnt_o is low.
  - Clears on grant or when req_i is low.
  - Maintained in all policies.
- rr_ptr is updated only under policy 00 and holds its value otherwise.
- A policy change takes effect in the same cycle, combinationally. State is kept across the change.
- Response path:
  - Per port, a RESP_LAT-deep shift register carries {valid, bank index}.
  - At stage 1, r_rdata is taken from rdata_i[bank]. Later stages register the data.
  - Write responses also assert r_valid_o. r_rdata_o is then don't-care but is driven from the bank.
- Ports may issue back-to-back requests. One response per grant, in order.

## Timing
- Grant-to-response latency is exactly RESP_LAT cycles for every granted request.
- Throughput: one access per bank per cycle.
- While rst_i is high:
  - gnt_o = 0 and req_o = 0.
  - r_valid_o = 0 and r_rdata_o = 0.
  - add_o, wen_o, wdata_o and be_o = 0.
  - rr_ptr, wait_cnt and the pipelines clear to 0.
- Reset mid-operation: in-flight responses are dropped, with no r_valid_o after reset. Arbitration restarts from port 0.
- Bank outputs are combinational from the winner. When req_o is low, data outputs are 0.
- The starvation bound under policy 11: a continuously requesting port is granted within STARVE_LIMIT+k cycles, where k is the number of lower-index ports that are also starved.

## Test plan
- Reset: hold rst_i 3 cycles with all req_i high → gnt_o = 0, r_valid_o = 0. First cycle after reset, policy 00, all ports to bank 0 → port 0 granted.
- Interleaving, NB_BANKS=16, BASE_ADDR=0x1000_0000:
  - Port 3 reads 0x1000_0044 → req_o[1] high, add_o[1] = 1, gnt_o[3] the same cycle.
  - With RESP_LAT=2, r_valid_o[3] two cycles later, carrying rdata_i[1] as sampled one cycle after the grant.
- Round-robin: ports 0, 5 and 9 continuously hit bank 2 under policy 00 → grants cycle 0, 5, 9, 0, …, each port once per 3 cycles.
- Fixed priority: policy 10, ports 1 and 14 hit bank 7 → port 14 is granted every cycle and port 1 is never granted. Switching to 01 → port 1 is granted in the same cycle.
- Starvation: policy 11, STARVE_LIMIT=4, ports 0 and 6 hit bank 3 continuously → port 6 is granted on cycle 5 and every 5th cycle thereafter; port 0 gets the rest.
- Writes: 4 back-to-back writes from port 2 to banks 0–3 → 4 grants in 4 cycles and 4 r_valid_o pulses RESP_LAT cycles later, in order. Assert rst_i after grant 2 → no r_valid_o after the reset cycle.
